// File: rtl/rob_multi_commit.sv
// Circular reorder buffer: one in-order allocation per cycle, WB_PORTS status
// writeback ports, in-order retirement of up to COMMIT_WIDTH DONE entries per
// cycle. A fault-class status at the head raises a precise exception and
// empties the buffer; an external flush empties it as well.
module rob_multi_commit #(
   parameter int ENTRIES      = 128,
   parameter int WB_PORTS     = 2,
   parameter int COMMIT_WIDTH = 2,
   parameter int PC_W         = 64,
   parameter int PREG_W       = 7,
   parameter int IDX_W        = $clog2(ENTRIES)
) (
   input  logic                           clk_in,
   input  logic                           rst_N_in,
   input  logic                           flush_in,
   // Allocation handshake: an allocation fires on the edge where
   // alloc_valid_in && alloc_ready_out; alloc_ready_out never depends on
   // alloc_valid_in.
   input  logic                           alloc_valid_in,
   output logic                           alloc_ready_out,
   input  logic [PC_W-1:0]                alloc_pc_in,
   input  logic [PREG_W-1:0]              alloc_dest_preg_in,
   output logic [IDX_W-1:0]               alloc_ptr_out,
   input  logic [WB_PORTS-1:0]            wb_valid_in,
   input  logic [WB_PORTS*IDX_W-1:0]      wb_ptr_in,
   input  logic [WB_PORTS*3-1:0]          wb_status_in,
   output logic [COMMIT_WIDTH-1:0]        commit_valid_out,
   output logic [COMMIT_WIDTH*PC_W-1:0]   commit_pc_out,
   output logic [COMMIT_WIDTH*PREG_W-1:0] commit_dest_preg_out,
   output logic                           exception_out,
   output logic [PC_W-1:0]                exception_pc_out,
   output logic [2:0]                     exception_status_out,
   output logic [IDX_W:0]                 count_out,
   output logic                           empty_out
);

   localparam logic [2:0]     ST_READY     = 3'd0;
   localparam logic [2:0]     ST_DONE      = 3'd2;
   localparam logic [2:0]     ST_EXCEPTION = 3'd3;
   localparam logic [2:0]     ST_INTERRUPT = 3'd4;
   localparam logic [2:0]     ST_TRAP      = 3'd5;
   localparam logic [IDX_W:0] DEPTH        = (IDX_W+1)'(ENTRIES);
   localparam logic [IDX_W:0] ONE          = (IDX_W+1)'(1);

   // Pointers carry a wrap bit above the index bits.
   logic [IDX_W:0]         head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [ENTRIES-1:0]     valid_q, valid_d;
   logic [2:0]             status_q [ENTRIES];
   logic [PC_W-1:0]        pc_q     [ENTRIES];
   logic [PREG_W-1:0]      dest_q   [ENTRIES];

   logic                   alloc_fire;
   logic [IDX_W-1:0]       tail_idx;
   logic [IDX_W-1:0]       slot_idx [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0] retire;
   logic [IDX_W:0]         num_ret;
   logic                   exc_hit;
   logic [IDX_W-1:0]       exc_idx;
   logic                   scan_on;

   logic [COMMIT_WIDTH-1:0]        commit_valid_q, commit_valid_d;
   logic [COMMIT_WIDTH*PC_W-1:0]   commit_pc_q, commit_pc_d;
   logic [COMMIT_WIDTH*PREG_W-1:0] commit_dest_q, commit_dest_d;
   logic                           exc_q, exc_d;
   logic [PC_W-1:0]                exc_pc_q, exc_pc_d;
   logic [2:0]                     exc_status_q, exc_status_d;

   assign tail_idx        = tail_q[IDX_W-1:0];
   assign alloc_ready_out = (count_q < DEPTH);
   assign alloc_fire      = alloc_valid_in && alloc_ready_out;
   assign alloc_ptr_out   = tail_idx;
   assign count_out       = count_q;
   assign empty_out       = (count_q == '0);

   // Entry index of each commit slot, wrapping modulo ENTRIES.
   always_comb begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         slot_idx[k] = head_q[IDX_W-1:0] + IDX_W'(k);
      end
   end

   // In-order scan from head: retire DONE entries, stop at the first
   // invalid/non-DONE entry, flag a fault-class status as an exception.
   always_comb begin
      retire  = '0;
      num_ret = '0;
      exc_hit = 1'b0;
      exc_idx = '0;
      scan_on = 1'b1;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (scan_on) begin
            if (!valid_q[slot_idx[k]]) begin
               scan_on = 1'b0;
            end else if (status_q[slot_idx[k]] == ST_DONE) begin
               retire[k] = 1'b1;
               num_ret   = num_ret + ONE;
            end else if (status_q[slot_idx[k]] == ST_EXCEPTION ||
                         status_q[slot_idx[k]] == ST_INTERRUPT ||
                         status_q[slot_idx[k]] == ST_TRAP) begin
               exc_hit = 1'b1;
               exc_idx = slot_idx[k];
               scan_on = 1'b0;
            end else begin
               scan_on = 1'b0;
            end
         end
      end
   end

   // Next pointers, count and valid bits; flush and exception empty the buffer.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (flush_in || exc_hit) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         valid_d = '0;
      end else begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (retire[k]) valid_d[slot_idx[k]] = 1'b0;
         end
         if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            tail_d            = tail_q + ONE;
         end
         head_d  = head_q + num_ret;
         count_d = count_q + (IDX_W+1)'(alloc_fire) - num_ret;
      end
   end

   // Registered commit/exception reports for the cycle after the edge.
   always_comb begin
      commit_valid_d = '0;
      commit_pc_d    = '0;
      commit_dest_d  = '0;
      exc_d          = 1'b0;
      exc_pc_d       = '0;
      exc_status_d   = '0;
      if (!flush_in) begin
         commit_valid_d = retire;
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (retire[k]) begin
               commit_pc_d[k*PC_W +: PC_W]       = pc_q[slot_idx[k]];
               commit_dest_d[k*PREG_W +: PREG_W] = dest_q[slot_idx[k]];
            end
         end
         if (exc_hit) begin
            exc_d        = 1'b1;
            exc_pc_d     = pc_q[exc_idx];
            exc_status_d = status_q[exc_idx];
         end
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         valid_q        <= '0;
         commit_valid_q <= '0;
         commit_pc_q    <= '0;
         commit_dest_q  <= '0;
         exc_q          <= 1'b0;
         exc_pc_q       <= '0;
         exc_status_q   <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         valid_q        <= valid_d;
         commit_valid_q <= commit_valid_d;
         commit_pc_q    <= commit_pc_d;
         commit_dest_q  <= commit_dest_d;
         exc_q          <= exc_d;
         exc_pc_q       <= exc_pc_d;
         exc_status_q   <= exc_status_d;
      end
   end

   // Entry payload; only meaningful while valid, so it needs no reset.
   // Later ports overwrite earlier ones, so the highest port index wins.
   always_ff @(posedge clk_in) begin
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid_in[p] && valid_q[wb_ptr_in[p*IDX_W +: IDX_W]]) begin
            status_q[wb_ptr_in[p*IDX_W +: IDX_W]] <= wb_status_in[p*3 +: 3];
         end
      end
      if (alloc_fire) begin
         pc_q[tail_idx]     <= alloc_pc_in;
         dest_q[tail_idx]   <= alloc_dest_preg_in;
         status_q[tail_idx] <= ST_READY;
      end
   end

   assign commit_valid_out     = commit_valid_q;
   assign commit_pc_out        = commit_pc_q;
   assign commit_dest_preg_out = commit_dest_q;
   assign exception_out        = exc_q;
   assign exception_pc_out     = exc_pc_q;
   assign exception_status_out = exc_status_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed scenarios plus random traffic, each
// cycle compared against a queue-based model of the in-flight instructions.
module tb_rob_multi_commit;

   localparam int ENTRIES = 128;
   localparam int WBP     = 2;
   localparam int CW      = 2;
   localparam int PC_W    = 64;
   localparam int PREG_W  = 7;
   localparam int IDX_W   = 7;

   localparam int S_READY = 0, S_ISSUED = 1, S_DONE = 2;
   localparam int S_EXC = 3, S_INT = 4, S_TRAP = 5;

   // clock / reset
   logic clk_in = 1'b0;
   logic rst_N_in;
   always #5 clk_in = ~clk_in;

   logic                      flush_in;
   logic                      alloc_valid_in;
   logic                      alloc_ready_out;
   logic [PC_W-1:0]           alloc_pc_in;
   logic [PREG_W-1:0]         alloc_dest_preg_in;
   logic [IDX_W-1:0]          alloc_ptr_out;
   logic [WBP-1:0]            wb_valid_in;
   logic [WBP*IDX_W-1:0]      wb_ptr_in;
   logic [WBP*3-1:0]          wb_status_in;
   logic [CW-1:0]             commit_valid_out;
   logic [CW*PC_W-1:0]        commit_pc_out;
   logic [CW*PREG_W-1:0]      commit_dest_preg_out;
   logic                      exception_out;
   logic [PC_W-1:0]           exception_pc_out;
   logic [2:0]                exception_status_out;
   logic [IDX_W:0]            count_out;
   logic                      empty_out;

   rob_multi_commit #(
      .ENTRIES(ENTRIES), .WB_PORTS(WBP), .COMMIT_WIDTH(CW),
      .PC_W(PC_W), .PREG_W(PREG_W)
   ) dut (
      .clk_in(clk_in), .rst_N_in(rst_N_in), .flush_in(flush_in),
      .alloc_valid_in(alloc_valid_in), .alloc_ready_out(alloc_ready_out),
      .alloc_pc_in(alloc_pc_in), .alloc_dest_preg_in(alloc_dest_preg_in),
      .alloc_ptr_out(alloc_ptr_out), .wb_valid_in(wb_valid_in),
      .wb_ptr_in(wb_ptr_in), .wb_status_in(wb_status_in),
      .commit_valid_out(commit_valid_out), .commit_pc_out(commit_pc_out),
      .commit_dest_preg_out(commit_dest_preg_out),
      .exception_out(exception_out), .exception_pc_out(exception_pc_out),
      .exception_status_out(exception_status_out),
      .count_out(count_out), .empty_out(empty_out)
   );

   // reference model: in-flight instructions in program order, head first
   typedef struct {
      logic [PC_W-1:0]   pc;
      logic [PREG_W-1:0] dest;
      int                st;
   } ent_t;
   ent_t rob_q[$];
   int   m_head;

   // scoreboard: retirements expected to be reported after the next edge
   logic [PREG_W+PC_W-1:0] exp_q[$];
   logic [CW-1:0]          exp_cv;
   logic                   exp_exc;
   logic [PC_W-1:0]        exp_exc_pc;
   logic [2:0]             exp_exc_st;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   // driver tasks
   task automatic clear_in();
      flush_in = 1'b0; alloc_valid_in = 1'b0; alloc_pc_in = '0;
      alloc_dest_preg_in = '0; wb_valid_in = '0; wb_ptr_in = '0; wb_status_in = '0;
   endtask

   task automatic set_alloc(input logic [PC_W-1:0] pc, input int dest);
      alloc_valid_in = 1'b1; alloc_pc_in = pc; alloc_dest_preg_in = PREG_W'(dest);
   endtask

   task automatic set_wb(input int p, input int ptr, input int st);
      wb_valid_in[p] = 1'b1;
      wb_ptr_in[p*IDX_W +: IDX_W] = IDX_W'(ptr);
      wb_status_in[p*3 +: 3] = 3'(st);
   endtask

   task automatic model_reset();
      rob_q.delete(); exp_q.delete(); m_head = 0; exp_cv = '0; exp_exc = 1'b0;
   endtask

   // What the next rising edge does, from the instruction-level rules.
   task automatic model_edge();
      int  n, size_pre, off;
      bit  stop;
      ent_t e;
      exp_cv = '0; exp_exc = 1'b0; exp_exc_pc = '0; exp_exc_st = '0;
      if (flush_in) begin
         rob_q.delete(); m_head = 0;
         return;
      end
      size_pre = rob_q.size();
      n = 0; stop = 0;
      for (int k = 0; k < CW; k++) begin
         if (!stop && k < size_pre) begin
            if (rob_q[k].st == S_DONE) begin
               exp_cv[k] = 1'b1;
               exp_q.push_back({rob_q[k].dest, rob_q[k].pc});
               n++;
            end else if (rob_q[k].st >= S_EXC && rob_q[k].st <= S_TRAP) begin
               exp_exc = 1'b1; exp_exc_pc = rob_q[k].pc; exp_exc_st = 3'(rob_q[k].st);
               stop = 1;
            end else begin
               stop = 1;
            end
         end
      end
      for (int p = 0; p < WBP; p++) begin
         if (wb_valid_in[p]) begin
            off = (int'(wb_ptr_in[p*IDX_W +: IDX_W]) - m_head + ENTRIES) % ENTRIES;
            if (off < size_pre) rob_q[off].st = int'(wb_status_in[p*3 +: 3]);
         end
      end
      if (exp_exc) begin
         rob_q.delete(); m_head = 0;
         return;
      end
      repeat (n) void'(rob_q.pop_front());
      m_head = (m_head + n) % ENTRIES;
      if (alloc_valid_in && size_pre < ENTRIES) begin
         e.pc = alloc_pc_in; e.dest = alloc_dest_preg_in; e.st = S_READY;
         rob_q.push_back(e);
      end
   endtask

   task automatic check_outputs();
      logic [PREG_W+PC_W-1:0] e;
      check("count", 64'(count_out), 64'(rob_q.size()));
      check("empty", 64'(empty_out), 64'(rob_q.size() == 0));
      check("alloc_ready", 64'(alloc_ready_out), 64'(rob_q.size() < ENTRIES));
      check("alloc_ptr", 64'(alloc_ptr_out), 64'((m_head + rob_q.size()) % ENTRIES));
      check("commit_valid", 64'(commit_valid_out), 64'(exp_cv));
      for (int k = 0; k < CW; k++) begin
         if (exp_cv[k] && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("commit_pc", commit_pc_out[k*PC_W +: PC_W], e[PC_W-1:0]);
            check("commit_dest", 64'(commit_dest_preg_out[k*PREG_W +: PREG_W]),
                  64'(e[PREG_W+PC_W-1:PC_W]));
         end
      end
      check("exception", 64'(exception_out), 64'(exp_exc));
      if (exp_exc) begin
         check("exc_pc", exception_pc_out, exp_exc_pc);
         check("exc_status", 64'(exception_status_out), 64'(exp_exc_st));
      end
   endtask

   // one clock: model the edge, let the DUT take it, compare at the falling edge
   task automatic tick();
      model_edge();
      @(posedge clk_in);
      @(negedge clk_in);
      check_outputs();
      clear_in();
   endtask

   task automatic flush_all();
      flush_in = 1'b1;
      tick();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_count"}, 64'(count_out), 64'd0);
      check({tag, "_empty"}, 64'(empty_out), 64'd1);
      check({tag, "_ready"}, 64'(alloc_ready_out), 64'd1);
      check({tag, "_ptr"}, 64'(alloc_ptr_out), 64'd0);
      check({tag, "_cv"}, 64'(commit_valid_out), 64'd0);
      check({tag, "_exc"}, 64'(exception_out), 64'd0);
      check({tag, "_exc_pc"}, exception_pc_out, 64'd0);
   endtask

   initial begin
      int ptr, r, st;
      clear_in();
      model_reset();
      rst_N_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check_reset_values("reset");
      rst_N_in = 1'b1;

      // out-of-order completion, in-order retirement
      set_alloc(64'h100, 5); tick();
      set_alloc(64'h104, 6); tick();
      set_alloc(64'h108, 7); tick();
      set_wb(0, 2, S_DONE); tick();
      check("ooo_no_commit", 64'(commit_valid_out), 64'd0);
      set_wb(0, 0, S_DONE); tick();
      set_wb(1, 1, S_DONE); tick();
      check("ooo_slot0", 64'(commit_valid_out), 64'b01);
      check("ooo_slot0_pc", commit_pc_out[PC_W-1:0], 64'h100);
      tick();
      check("ooo_pair", 64'(commit_valid_out), 64'b11);
      check("ooo_pair_pc1", commit_pc_out[2*PC_W-1:PC_W], 64'h108);
      check("ooo_empty", 64'(empty_out), 64'd1);

      // fill to capacity; a commit in the same cycle does not admit an allocation
      flush_all();
      for (int i = 0; i < ENTRIES; i++) begin
         set_alloc(64'h1000 + 64'(4 * i), i % 128); tick();
      end
      check("full_count", 64'(count_out), 64'd128);
      check("full_ready", 64'(alloc_ready_out), 64'd0);
      set_alloc(64'hdead0, 1); set_wb(0, 0, S_DONE); tick();
      set_alloc(64'hdead4, 2); tick();
      check("full_no_alloc", 64'(count_out), 64'd127);
      check("full_ready_again", 64'(alloc_ready_out), 64'd1);
      set_alloc(64'hdead8, 3); tick();

      // trap behind a DONE entry
      flush_all();
      set_alloc(64'h200, 10); tick();
      set_alloc(64'h204, 11); tick();
      set_alloc(64'h208, 12); tick();
      set_wb(0, 0, S_DONE); set_wb(1, 1, S_TRAP); tick();
      set_alloc(64'h20c, 13); tick();
      check("trap_exc", 64'(exception_out), 64'd1);
      check("trap_pc", exception_pc_out, 64'h204);
      check("trap_status", 64'(exception_status_out), 64'd5);
      check("trap_count", 64'(count_out), 64'd0);
      set_wb(0, 2, S_DONE); tick();
      check("trap_wb_dropped", 64'(count_out), 64'd0);

      // two ports on one entry: port 1 wins
      flush_all();
      for (int i = 0; i < 5; i++) begin
         set_alloc(64'h300 + 64'(4 * i), 20 + i); tick();
      end
      set_wb(0, 4, S_EXC); set_wb(1, 4, S_DONE); tick();
      set_wb(0, 0, S_DONE); set_wb(1, 1, S_DONE); tick();
      set_wb(0, 2, S_DONE); set_wb(1, 3, S_DONE); tick();
      repeat (4) tick();
      check("port_prio_empty", 64'(empty_out), 64'd1);

      // move head to 126, then a group that straddles the wrap
      flush_all();
      for (int i = 0; i < 126; i++) begin
         set_alloc(64'h4000 + 64'(4 * i), i % 128);
         if (i > 0) set_wb(0, i - 1, S_DONE);
         tick();
      end
      set_wb(0, 125, S_DONE); tick();
      repeat (2) tick();
      check("wrap_ptr126", 64'(alloc_ptr_out), 64'd126);
      for (int i = 0; i < 4; i++) begin
         set_alloc(64'h5000 + 64'(4 * i), 30 + i); tick();
      end
      set_wb(0, 126, S_DONE); set_wb(1, 127, S_DONE); tick();
      set_wb(0, 0, S_DONE); set_wb(1, 1, S_DONE); tick();
      repeat (3) tick();
      check("wrap_ptr2", 64'(alloc_ptr_out), 64'd2);

      // flush with traffic and pending commits
      flush_all();
      for (int i = 0; i < 10; i++) begin
         set_alloc(64'h6000 + 64'(4 * i), i); tick();
      end
      set_wb(0, 0, S_DONE); set_wb(1, 1, S_DONE); tick();
      flush_in = 1'b1; set_alloc(64'h7000, 1); set_wb(0, 2, S_DONE); tick();
      check("flush_count", 64'(count_out), 64'd0);
      check("flush_cv", 64'(commit_valid_out), 64'd0);
      check("flush_ptr", 64'(alloc_ptr_out), 64'd0);

      // asynchronous reset while a commit is being reported
      set_alloc(64'h8000, 1); tick();
      set_alloc(64'h8004, 2); tick();
      set_wb(0, 0, S_DONE); tick();
      tick();
      check("pre_reset_cv", 64'(commit_valid_out), 64'b01);
      #2 rst_N_in = 1'b0;
      #1 check_reset_values("async_reset");
      model_reset();
      @(negedge clk_in);
      rst_N_in = 1'b1;

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 65)
            set_alloc({$urandom(), $urandom()}, int'($urandom_range(0, 127)));
         for (int p = 0; p < WBP; p++) begin
            if ($urandom_range(0, 99) < 60) begin
               if (rob_q.size() > 0 && $urandom_range(0, 19) != 0)
                  ptr = (m_head + int'($urandom_range(0, rob_q.size() - 1))) % ENTRIES;
               else
                  ptr = int'($urandom_range(0, ENTRIES - 1));
               r = int'($urandom_range(0, 199));
               if (r < 160)      st = S_DONE;
               else if (r < 176) st = S_ISSUED;
               else if (r < 192) st = S_READY;
               else              st = S_EXC + (r % 3);
               set_wb(p, ptr, st);
            end
         end
         if ($urandom_range(0, 99) == 0) flush_in = 1'b1;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
